modn_time_counter: RTL
======================

Name: modn_time_counter

Overview:
- Parametrised modulo-N time-digit counter; successor to the fixed mod-10 digit counter used in the clock datapath.
- One instance covers any clock digit: seconds/minutes units (N=10), tens (N=6), hour digits (N=10/3/2/12/24 via MODULUS).
- Adds up/down counting, parallel load, enable-based ticking on a single clock, and both carry and borrow outputs for cascading.
- Instances are chained by feeding one stage's carry/borrow into the next stage's tick_en.

Parameters:
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..256.
- WIDTH, 4, count width; must satisfy 2**WIDTH >= MODULUS (elaboration-time check, fatal otherwise).
- SET_CARRY_EN, 0, 1 = carry/borrow also pulse on wrap during set-time adjust; 0 = suppressed during adjust.

Ports:
- clkmain  in  1  single system clock; all state updates on rising edge.
- clear  in  1  synchronous, active-high reset.
- tick_en  in  1  run-mode count enable: 1 s tick or upstream carry/borrow, one cycle wide.
- adj_tick  in  1  fast adjust enable, used only while set_time=1 and slt=1.
- set_time  in  1  time-setting mode.
- slt  in  1  selects this digit for adjustment in set mode.
- dir  in  1  0 = count up, 1 = count down; applies in both run and adjust.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current digit value.
- carry  out  1  one-cycle pulse on up-wrap MODULUS-1 -> 0.
- borrow  out  1  one-cycle pulse on down-wrap 0 -> MODULUS-1.
- load_err  out  1  one-cycle pulse when load_val >= MODULUS.

Behaviour:
- All outputs are registered. Reset values: count=0, carry=0, borrow=0, load_err=0.
- Priority per edge, highest first: clear, load, set mode, run.
- clear=1: all outputs go to 0 on the next edge, overriding every other input (including mid-adjust and mid-load).
- load=1 with load_val < MODULUS: count <= load_val; carry=borrow=0.
- load=1 with load_val >= MODULUS: count unchanged; load_err=1 for one cycle; carry=borrow=0.
- set_time=1, slt=0 (hold): count unchanged; carry=borrow=0; tick_en and adj_tick are ignored.
- set_time=1, slt=1 (adjust):
  - Steps only on adj_tick=1; tick_en is ignored.
  - Wrap rules are the same as run mode.
  - carry/borrow pulse only if SET_CARRY_EN=1; otherwise held at 0.
- set_time=0 (run): steps only on tick_en=1; adj_tick and slt are ignored.
- Up step: count = MODULUS-1 -> 0 with carry=1; otherwise count+1 with carry=0.
- Down step: count = 0 -> MODULUS-1 with borrow=1; otherwise count-1 with borrow=0.
- carry and borrow are never high in the same cycle.
- Both outputs are 0 on any cycle without a step. They go high on the same edge that updates count to the wrapped value, so a downstream stage sees the pulse in the cycle count shows the wrapped value.
- Latency: one clock from enable to count update. A continuous tick_en advances count by one per cycle with no missed or doubled steps.
- dir may change between ticks; it is sampled on the stepping edge only.
- Arithmetic is performed in WIDTH bits with an explicit compare against MODULUS-1. Values >= MODULUS are unreachable after reset.

Decomposition:
- Shared package clock_pkg:
  - Digit modulus constants: SEC_U=10, SEC_T=6, MIN_U=10, MIN_T=6, HR24_U=10, HR24_T=3.
  - Mode enum derived from {set_time, slt}: RUN, HOLD, ADJUST.
  - Function clog2_mod for WIDTH derivation.
- No sub-module: the next-state/wrap logic is a single combinational block plus an output register.

Test Plan:
- MODULUS=10, clear, then 10 tick_en pulses with dir=0 -> count 1..9 then 0; carry=1 only on the 10th step's edge.
- MODULUS=6, dir=1 from count=0, one tick_en -> count=5 and borrow=1 for one cycle; carry stays 0.
- set_time=1, slt=0 at count=7, 5 tick_en and 5 adj_tick pulses -> count stays 7; carry=borrow=0 throughout.
- set_time=1, slt=1, SET_CARRY_EN=0, MODULUS=10, count=8, 3 adj_tick pulses -> count 9, 0, 1; carry never asserted. Repeat with SET_CARRY_EN=1 -> carry=1 on the 9->0 step.
- MODULUS=6, load=1 with load_val=7 -> count unchanged and load_err=1 for one cycle. Then load_val=4 -> count=4 and load_err=0.
- load=1 and tick_en=1 asserted together with clear=1 at count=5 -> count=0 and all pulses 0. Next cycle, tick_en alone -> count=1.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared clock-datapath package: digit moduli,
// digit mode decode and width helper.
package clock_pkg;

  localparam int SEC_U  = 10;
  localparam int SEC_T  = 6;
  localparam int MIN_U  = 10;
  localparam int MIN_T  = 6;
  localparam int HR24_U = 10;
  localparam int HR24_T = 3;

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    ADJUST
  } mode_t;

  function automatic mode_t mode_of(
    input logic set_time,
    input logic slt
  );
    if (!set_time)
      return RUN;
    return slt ? ADJUST : HOLD;
  endfunction

  function automatic int clog2_mod(input int m);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << w) < 64'(m))
        w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/modn_time_counter.sv
// Modulo-N up/down time digit with load, adjust mode
// and carry/borrow/load_err pulses.
// Ports: clkmain, clear (sync reset), tick_en,
// adj_tick, set_time, slt, dir, load, load_val ->
// count, carry, borrow, load_err (all registered).
module modn_time_counter
  import clock_pkg::*;
#(
  parameter int MODULUS      = 10,
  parameter int WIDTH        = 4,
  parameter int SET_CARRY_EN = 0
) (
  input  logic             clkmain,
  input  logic             clear,
  input  logic             tick_en,
  input  logic             adj_tick,
  input  logic             set_time,
  input  logic             slt,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > 256) begin : g_bad_mod
    $fatal(1, "MODULUS out of range 2..256");
  end
  if (WIDTH < clog2_mod(MODULUS)) begin : g_bad_w
    $fatal(1, "WIDTH too small for MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX =
    WIDTH'(MODULUS - 1);
  localparam logic SCE = (SET_CARRY_EN != 0);

  mode_t            mode;
  logic             step;
  logic             pulse_ok;
  logic [WIDTH-1:0] nxt_count;
  logic             nxt_carry;
  logic             nxt_borrow;
  logic             nxt_err;

  always_comb begin
    mode       = mode_of(set_time, slt);
    step       = 1'b0;
    nxt_count  = count;
    nxt_carry  = 1'b0;
    nxt_borrow = 1'b0;
    nxt_err    = 1'b0;

    unique case (mode)
      RUN:     step = tick_en;
      ADJUST:  step = adj_tick;
      HOLD:    step = 1'b0;
      default: step = 1'b0;
    endcase

    // wrap pulses are muted while adjusting
    // unless the instance opts in
    pulse_ok = (mode == RUN) || SCE;

    if (load) begin
      if (load_val > MAX)
        nxt_err = 1'b1;
      else
        nxt_count = load_val;
    end else if (step) begin
      if (!dir) begin
        if (count == MAX) begin
          nxt_count = '0;
          nxt_carry = pulse_ok;
        end else begin
          nxt_count = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          nxt_count  = MAX;
          nxt_borrow = pulse_ok;
        end else begin
          nxt_count = count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkmain) begin
    if (clear) begin
      count    <= '0;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= nxt_count;
      carry    <= nxt_carry;
      borrow   <= nxt_borrow;
      load_err <= nxt_err;
    end
  end

endmodule
